simd_operand_dispatcher: RTL and testbench

- Upstream feeder for the Processing_Element lane array.
- Accepts a serial stream of N-bit operand words over a valid/ready handshake and packs them into LANES-wide A and B operand vectors.
- Clears the PE multipliers, fires a single-cycle start, then holds operands stable until the lanes report done.
- Sits between the instruction/operand fetch unit and the PE array in the SIMD datapath.

---
 rtl/simd_operand_dispatcher.sv | 193 +++++++++++++++++++
 tb/tb_simd_operand_dispatcher.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/simd_operand_dispatcher.sv
// Packs a serial operand stream into LANES-wide A/B vectors and sequences the PE lanes.
// Optional macro DISPATCH_DOUBLE_BUFFER_EN lets the next frame load while the lanes compute.
module simd_operand_dispatcher #(
    parameter int N     = 16,
    parameter int LANES = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [N-1:0]       IN_DATA,
    input  logic [1:0]         IN_OP,
    output logic [LANES*N-1:0] PE_A,
    output logic [LANES*N-1:0] PE_B,
    output logic [1:0]         PE_OP,
    output logic               RST_MUL,
    output logic               PE_START,
    input  logic               PE_DONE,
    output logic               BUSY
);

    localparam int FW = 2 * LANES;
    localparam int CW = (FW > 1) ? $clog2(FW) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FW - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_CLEAR = 2'd1,
        S_ISSUE = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [LANES*N-1:0] stage_a_q, stage_a_d;
    logic [LANES*N-1:0] stage_b_q, stage_b_d;
    logic [1:0]         stage_op_q, stage_op_d;
    logic [LANES*N-1:0] pe_a_q, pe_a_d;
    logic [LANES*N-1:0] pe_b_q, pe_b_d;
    logic [1:0]         pe_op_q, pe_op_d;
    logic               rst_mul_q;
    logic               pe_start_q;
    logic               busy_q;
    logic               ready_s;
    logic               xfer_s;
    logic               last_s;
`ifdef DISPATCH_DOUBLE_BUFFER_EN
    logic               full_q, full_d;
`endif

    // Acceptance window: LOAD only, or also WAIT while the staging frame is not yet full
    always_comb begin
`ifdef DISPATCH_DOUBLE_BUFFER_EN
        ready_s = (state_q == S_LOAD) || ((state_q == S_WAIT) && !full_q);
`else
        ready_s = (state_q == S_LOAD);
`endif
        xfer_s = IN_VALID && ready_s;
        last_s = xfer_s && (cnt_q == CNT_LAST);
    end

    assign IN_READY = ready_s && !RST;

    // Next-state, staging writes and output-register loads
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stage_a_d  = stage_a_q;
        stage_b_d  = stage_b_q;
        stage_op_d = stage_op_q;
        pe_a_d     = pe_a_q;
        pe_b_d     = pe_b_q;
        pe_op_d    = pe_op_q;
`ifdef DISPATCH_DOUBLE_BUFFER_EN
        full_d     = full_q;
`endif
        if (xfer_s) begin
            cnt_d = last_s ? CNT_ZERO : (cnt_q + CNT_ONE);
            if (cnt_q == CNT_ZERO) begin
                stage_op_d = IN_OP;
            end else begin
                stage_op_d = stage_op_q;
            end
            for (int k = 0; k < LANES; k++) begin
                if (cnt_q == CW'(k)) begin
                    stage_a_d[k*N +: N] = IN_DATA;
                end else begin
                    stage_a_d[k*N +: N] = stage_a_q[k*N +: N];
                end
                if (cnt_q == CW'(LANES + k)) begin
                    stage_b_d[k*N +: N] = IN_DATA;
                end else begin
                    stage_b_d[k*N +: N] = stage_b_q[k*N +: N];
                end
            end
        end else begin
            cnt_d = cnt_q;
        end

        case (state_q)
            S_LOAD: begin
                if (last_s) begin
                    state_d = S_CLEAR;
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_CLEAR: begin
                pe_a_d  = stage_a_q;
                pe_b_d  = stage_b_q;
                pe_op_d = stage_op_q;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
`ifdef DISPATCH_DOUBLE_BUFFER_EN
                // A frame completing on the same edge as PE_DONE counts as staged
                if (PE_DONE) begin
                    if (full_q || last_s) begin
                        state_d = S_CLEAR;
                        full_d  = 1'b0;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_WAIT;
                    if (last_s) begin
                        full_d = 1'b1;
                    end else begin
                        full_d = full_q;
                    end
                end
`else
                if (PE_DONE) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_WAIT;
                end
`endif
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // State, staging and output registers; pulses are aligned with the CLEAR/ISSUE states
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_LOAD;
            cnt_q      <= CNT_ZERO;
            stage_a_q  <= {(LANES*N){1'b0}};
            stage_b_q  <= {(LANES*N){1'b0}};
            stage_op_q <= 2'b00;
            pe_a_q     <= {(LANES*N){1'b0}};
            pe_b_q     <= {(LANES*N){1'b0}};
            pe_op_q    <= 2'b00;
            rst_mul_q  <= 1'b0;
            pe_start_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef DISPATCH_DOUBLE_BUFFER_EN
            full_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stage_a_q  <= stage_a_d;
            stage_b_q  <= stage_b_d;
            stage_op_q <= stage_op_d;
            pe_a_q     <= pe_a_d;
            pe_b_q     <= pe_b_d;
            pe_op_q    <= pe_op_d;
            rst_mul_q  <= (state_d == S_CLEAR);
            pe_start_q <= (state_d == S_ISSUE);
            busy_q     <= (state_d != S_LOAD) || (cnt_d != CNT_ZERO);
`ifdef DISPATCH_DOUBLE_BUFFER_EN
            full_q     <= full_d;
`endif
        end
    end

    assign PE_A     = pe_a_q;
    assign PE_B     = pe_b_q;
    assign PE_OP    = pe_op_q;
    assign RST_MUL  = rst_mul_q;
    assign PE_START = pe_start_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_simd_operand_dispatcher.sv
// Directed self-checking bench for simd_operand_dispatcher (N=16, LANES=4).
module tb_simd_operand_dispatcher;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [15:0] IN_DATA = 16'h0000;
    logic [1:0]  IN_OP = 2'b00;
    logic [63:0] PE_A;
    logic [63:0] PE_B;
    logic [1:0]  PE_OP;
    logic        RST_MUL;
    logic        PE_START;
    logic        PE_DONE = 1'b0;
    logic        BUSY;

    int tests = 0;
    int fails = 0;
    int starts = 0;

`ifdef DISPATCH_DOUBLE_BUFFER_EN
    localparam logic WAIT_RDY = 1'b1;
`else
    localparam logic WAIT_RDY = 1'b0;
`endif

    simd_operand_dispatcher #(.N(16), .LANES(4)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .IN_DATA(IN_DATA), .IN_OP(IN_OP), .PE_A(PE_A), .PE_B(PE_B),
        .PE_OP(PE_OP), .RST_MUL(RST_MUL), .PE_START(PE_START),
        .PE_DONE(PE_DONE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(negedge CLK);
        if (PE_START === 1'b1) starts++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Word i of a frame is base + inc*i; opcode op0 on word 0, opr afterwards
    task automatic send_frame(input logic [15:0] base, input logic [15:0] inc,
                              input logic [1:0] op0, input logic [1:0] opr, input bit stall);
        for (int i = 0; i < 8; i++) begin
            if (stall && i > 0) step();
            IN_VALID = 1'b1;
            IN_DATA  = base + inc * 16'(i);
            IN_OP    = (i == 0) ? op0 : opr;
            step();
            IN_VALID = 1'b0;
        end
    endtask

    function automatic logic [63:0] lanes(input logic [15:0] base, input logic [15:0] inc, input int first);
        logic [63:0] v;
        v = 64'h0;
        for (int k = 0; k < 4; k++) v[k*16 +: 16] = base + inc * 16'(first + k);
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held for two cycles
        step();
        check("ready_in_reset", {63'h0, IN_READY}, 64'h0);
        step();
        RST = 1'b0;
        #1;
        check("rst_ready", {63'h0, IN_READY}, 64'h1);
        check("rst_busy", {63'h0, BUSY}, 64'h0);
        check("rst_pe_a", PE_A, 64'h0);
        check("rst_pe_b", PE_B, 64'h0);
        check("rst_pe_op", {62'h0, PE_OP}, 64'h0);
        check("rst_pulses", {62'h0, RST_MUL, PE_START}, 64'h0);

        // PE_DONE in LOAD has no effect
        PE_DONE = 1'b1;
        step();
        PE_DONE = 1'b0;
        check("done_in_load_ready", {63'h0, IN_READY}, 64'h1);
        check("done_in_load_busy", {63'h0, BUSY}, 64'h0);

        // Basic back-to-back frame
        starts = 0;
        send_frame(16'h0001, 16'h0001, 2'd2, 2'd2, 1'b0);
        check("basic_clear_pulses", {62'h0, RST_MUL, PE_START}, 64'h2);
        check("basic_clear_ready", {63'h0, IN_READY}, 64'h0);
        check("basic_clear_busy", {63'h0, BUSY}, 64'h1);
        check("basic_clear_pe_a_old", PE_A, 64'h0);
        step();
        check("basic_issue_pulses", {62'h0, RST_MUL, PE_START}, 64'h1);
        check("basic_pe_a", PE_A, 64'h0004_0003_0002_0001);
        check("basic_pe_b", PE_B, 64'h0008_0007_0006_0005);
        check("basic_pe_op", {62'h0, PE_OP}, 64'h2);
        repeat (4) step();
        check("basic_wait_pulses", {62'h0, RST_MUL, PE_START}, 64'h0);
        check("basic_wait_ready", {63'h0, IN_READY}, {63'h0, WAIT_RDY});
        check("basic_wait_hold_a", PE_A, 64'h0004_0003_0002_0001);
        PE_DONE = 1'b1;
        step();
        PE_DONE = 1'b0;
        check("basic_done_ready", {63'h0, IN_READY}, 64'h1);
        check("basic_done_busy", {63'h0, BUSY}, 64'h0);
        check("basic_start_count", 64'(starts), 64'd1);

        // Stalled stream; PE_DONE held through CLEAR and ISSUE must be ignored
        starts = 0;
        send_frame(16'h0001, 16'h0001, 2'd2, 2'd2, 1'b1);
        PE_DONE = 1'b1;
        step();
        check("stall_pe_a", PE_A, 64'h0004_0003_0002_0001);
        check("stall_pe_b", PE_B, 64'h0008_0007_0006_0005);
        step();
        PE_DONE = 1'b0;
        step();
        check("stall_still_wait_busy", {63'h0, BUSY}, 64'h1);
        check("stall_still_wait_ready", {63'h0, IN_READY}, {63'h0, WAIT_RDY});
        check("stall_start_count", 64'(starts), 64'd1);
        PE_DONE = 1'b1;
        step();
        PE_DONE = 1'b0;

        // Opcode latched from word 0 only
        send_frame(16'h0010, 16'h0001, 2'd1, 2'd3, 1'b0);
        step();
        check("op_latch_pe_op", {62'h0, PE_OP}, 64'h1);
        check("op_latch_pe_a", PE_A, 64'h0013_0012_0011_0010);
        check("op_latch_pe_b", PE_B, 64'h0017_0016_0015_0014);
        step();
        PE_DONE = 1'b1;
        step();
        PE_DONE = 1'b0;

        // Reset mid-frame discards the partial frame
        for (int i = 0; i < 3; i++) begin
            IN_VALID = 1'b1;
            IN_DATA  = 16'hBEE0 + 16'(i);
            IN_OP    = 2'd3;
            step();
            IN_VALID = 1'b0;
        end
        check("partial_busy", {63'h0, BUSY}, 64'h1);
        check("partial_ready", {63'h0, IN_READY}, 64'h1);
        RST = 1'b1;
        #1;
        check("midframe_rst_busy", {63'h0, BUSY}, 64'h0);
        check("midframe_rst_pe_a", PE_A, 64'h0);
        step();
        RST = 1'b0;
        starts = 0;
        send_frame(16'h0A00, 16'h0011, 2'd1, 2'd2, 1'b0);
        step();
        check("after_abort_pe_a", PE_A, lanes(16'h0A00, 16'h0011, 0));
        check("after_abort_pe_b", PE_B, lanes(16'h0A00, 16'h0011, 4));
        check("after_abort_pe_op", {62'h0, PE_OP}, 64'h1);

        // Reset mid-WAIT
        step();
        check("premid_wait_start", {63'h0, PE_START}, 64'h0);
        RST = 1'b1;
        #1;
        check("midwait_rst_pe_a", PE_A, 64'h0);
        check("midwait_rst_pe_b", PE_B, 64'h0);
        check("midwait_rst_pe_op", {62'h0, PE_OP}, 64'h0);
        check("midwait_rst_flags", {60'h0, RST_MUL, PE_START, BUSY, IN_READY}, 64'h0);
        step();
        RST = 1'b0;
        #1;
        check("midwait_ready", {63'h0, IN_READY}, 64'h1);
        starts = 0;
        send_frame(16'hFFFF, 16'h0000, 2'd3, 2'd3, 1'b0);
        step();
        check("ffff_pe_a", PE_A, 64'hFFFF_FFFF_FFFF_FFFF);
        check("ffff_pe_b", PE_B, 64'hFFFF_FFFF_FFFF_FFFF);
        check("ffff_pe_op", {62'h0, PE_OP}, 64'h3);
        step();
        check("ffff_start_count", 64'(starts), 64'd1);
        PE_DONE = 1'b1;
        step();
        PE_DONE = 1'b0;

`ifdef DISPATCH_DOUBLE_BUFFER_EN
        // Second frame staged during WAIT, then issued straight from WAIT
        send_frame(16'h0001, 16'h0001, 2'd0, 2'd0, 1'b0);
        step();
        step();
        check("db_wait_ready", {63'h0, IN_READY}, 64'h1);
        send_frame(16'h0100, 16'h0001, 2'd1, 2'd1, 1'b0);
        check("db_full_ready", {63'h0, IN_READY}, 64'h0);
        check("db_full_hold_a", PE_A, 64'h0004_0003_0002_0001);
        step();
        check("db_no_clear_yet", {63'h0, RST_MUL}, 64'h0);
        PE_DONE = 1'b1;
        step();
        PE_DONE = 1'b0;
        check("db_clear_pulses", {62'h0, RST_MUL, PE_START}, 64'h2);
        check("db_clear_hold_a", PE_A, 64'h0004_0003_0002_0001);
        step();
        check("db_issue_pulses", {62'h0, RST_MUL, PE_START}, 64'h1);
        check("db_pe_a", PE_A, 64'h0103_0102_0101_0100);
        check("db_pe_b", PE_B, 64'h0107_0106_0105_0104);
        check("db_pe_op", {62'h0, PE_OP}, 64'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
